rand_checker: RTL and testbench
===============================

RAND_CHECKER -- requirements
Module: rand_checker

Interface
REQ-001 SHALL have parameter LOSS_THRESH, default 4: consecutive mismatched words in TRACK that force loss of lock (legal 1..15).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid  input  1  qualifies data for one cycle; idle cycles do not advance the checker.
REQ-005 SHALL have port data  input  12  received word; the low 12 bits of the team's 20-bit Fibonacci LFSR (taps 19,17,16,15; shift left; feedback into bit 0).
REQ-006 SHALL have port clear_cnt  input  1  synchronous clear of err_count.
REQ-007 SHALL have port locked  output  1  checker is tracking a consistent sequence.
REQ-008 SHALL have port error  output  1  one-cycle pulse per mismatched word while locked.
REQ-009 SHALL have port err_count  output  16  count of error pulses, saturating.
REQ-010 SHALL have port state_dbg  output  2  current FSM state encoding.

Function
REQ-011 SHALL hold a 20-bit shadow register hist and a 4-bit fill counter.
REQ-012 SHALL implement FSM states SEED=0, FILL=1, TRACK=2 and no other reachable state.
REQ-013 In SEED, on valid: SHALL load hist <= {8'h00, data}, set fill counter to 0, and go to FILL.
REQ-014 In FILL, on valid: SHALL check data[11:1] == hist[10:0]; on pass, hist <= {hist[18:0], data[0]} and increment fill counter; on fail, reseed hist from data as in SEED and reset fill counter.
REQ-015 SHALL leave FILL for TRACK on the 8th consecutive passing FILL word; hist then equals the generator's full 20-bit state.
REQ-016 On the FILL-to-TRACK transition, SHALL return to SEED instead if hist == 20'h00000 (LFSR lockup state).
REQ-017 In TRACK, SHALL form next = {hist[18:0], hist[19]^hist[17]^hist[16]^hist[15]} and expected word = next[11:0].
REQ-018 In TRACK, on valid with data == expected: SHALL set hist <= next and clear the mismatch counter.
REQ-019 In TRACK, on valid with data != expected: SHALL pulse error, advance hist <= next anyway, and increment the mismatch counter.
REQ-020 SHALL go to SEED, with locked low the next cycle, when the mismatch counter reaches LOSS_THRESH.
REQ-021 locked SHALL be a registered output, high exactly while the state is TRACK.
REQ-022 error SHALL be registered; it asserts the cycle after the offending valid word and is low otherwise.
REQ-023 No error pulses SHALL occur in SEED or FILL.
REQ-024 err_count SHALL increment by 1 per error pulse and hold at 16'hFFFF.
REQ-025 clear_cnt SHALL zero err_count in the same cycle as an increment, with clear taking priority; lock state is unaffected.
REQ-026 Cycles with valid low SHALL change no state other than error returning low and the clear_cnt effect.

Reset
REQ-027 On reset_n low, SHALL asynchronously set state=SEED, hist=0, fill counter=0, mismatch counter=0, locked=0, error=0, err_count=0, state_dbg=0.
REQ-028 Reset asserted mid-TRACK SHALL discard lock immediately; after release, reacquisition needs 9 fresh valid words.
REQ-029 Release of reset_n SHALL be treated as synchronous to clk by the integrator; no internal synchronizer.

Verification
REQ-030 Lock: generator seeded 20'h12345 feeding words 0x345, 0x68B, ... back-to-back -> locked rises the cycle after the 9th word, error never pulses, err_count = 0.
REQ-031 Gapped stream: same sequence with valid low on random cycles (up to 5-cycle gaps) -> identical lock point counted in words, no errors.
REQ-032 Single bit flip: after lock, corrupt one word (XOR 0x001) -> exactly one error pulse, err_count = 1, locked stays high.
REQ-033 Loss of lock: after lock, feed 4 consecutive wrong words with default LOSS_THRESH -> 4 error pulses, locked low the cycle after the 4th, state_dbg = 0.
REQ-034 Saturation/clear: preload via forced errors to 16'hFFFF, one more error -> stays 16'hFFFF; assert clear_cnt together with an error -> 0.
REQ-035 Reset mid-TRACK and all-zero stream: assert reset_n low while locked -> all outputs 0 asynchronously; nine 0x000 words -> never locks (SEED/FILL loop).

Source files
------------

// File: rtl/rand_checker.sv
// Receive-side checker for the 20-bit Fibonacci LFSR pattern (low 12 bits per word).
// Latency: locked/error/err_count update one cycle after the qualifying valid word.
// Backpressure: none; valid-only input, idle cycles leave the checker untouched.
module rand_checker #(
    parameter int LOSS_THRESH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic [11:0] data,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        error,
    output logic [15:0] err_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        FILL  = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t      state;
    logic [19:0] hist;
    logic [3:0]  fill_cnt;
    logic [3:0]  miss_cnt;

    logic [19:0] lfsr_next;
    logic [19:0] fill_hist;
    logic [11:0] expected;
    logic        fill_pass;
    logic        track_err;

    always_comb begin
        lfsr_next = {hist[18:0], hist[19] ^ hist[17] ^ hist[16] ^ hist[15]};
        expected  = lfsr_next[11:0];
        // hist[11:0] always holds the previous word, so a pass means this word is its left shift
        fill_pass = (data[11:1] == hist[10:0]);
        fill_hist = {hist[18:0], data[0]};
        track_err = valid && (state == TRACK) && (data != expected);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEED;
            hist      <= '0;
            fill_cnt  <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            error <= track_err;

            if (clear_cnt)
                err_count <= '0;
            else if (track_err && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;

            if (valid) begin
                case (state)
                    SEED: begin
                        hist     <= {8'h00, data};
                        fill_cnt <= '0;
                        state    <= FILL;
                    end
                    FILL: begin
                        if (fill_pass) begin
                            hist <= fill_hist;
                            if (fill_cnt == 4'd7) begin
                                fill_cnt <= '0;
                                // all-zero is the LFSR lockup state and can never be tracked
                                if (fill_hist == 20'h00000) begin
                                    state <= SEED;
                                end else begin
                                    state    <= TRACK;
                                    locked   <= 1'b1;
                                    miss_cnt <= '0;
                                end
                            end else begin
                                fill_cnt <= fill_cnt + 4'd1;
                            end
                        end else begin
                            hist     <= {8'h00, data};
                            fill_cnt <= '0;
                        end
                    end
                    TRACK: begin
                        hist <= lfsr_next;
                        if (data == expected) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == 4'(LOSS_THRESH - 1)) begin
                            state    <= SEED;
                            locked   <= 1'b0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state  <= SEED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rand_checker.sv
// Bench for rand_checker: vector table, hand sequences, randomized stream vs. a word-level model.
module tb_rand_checker;

    localparam int THRESH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid, clear_cnt;
    logic [11:0] data;
    logic        locked, error;
    logic [15:0] err_count;
    logic [1:0]  state_dbg;

    logic        valid2, clear2;
    logic [11:0] data2;
    logic        locked2, error2;
    logic [15:0] cnt2;
    logic [1:0]  dbg2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rand_checker dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear_cnt(clear_cnt),
        .locked(locked), .error(error), .err_count(err_count), .state_dbg(state_dbg)
    );

    rand_checker #(.LOSS_THRESH(15)) dut_sat (
        .clk(clk), .reset_n(reset_n), .valid(valid2), .data(data2), .clear_cnt(clear2),
        .locked(locked2), .error(error2), .err_count(cnt2), .state_dbg(dbg2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] lfsr_step(input logic [19:0] s);
        return {s[18:0], s[19] ^ s[17] ^ s[16] ^ s[15]};
    endfunction

    // Word-level model: a candidate run of consistent words, then free-running prediction.
    logic [11:0] run[$];
    logic [19:0] m_state;
    bit          m_locked;
    int          m_miss;
    bit          m_err;
    logic [15:0] m_cnt;

    task automatic model_reset();
        run.delete();
        m_state = '0; m_locked = 0; m_miss = 0; m_err = 0; m_cnt = '0;
    endtask

    task automatic model_edge(input bit v, input logic [11:0] d, input bit clr);
        logic [19:0] s;
        bit e = 0;
        if (v) begin
            if (m_locked) begin
                m_state = lfsr_step(m_state);
                if (d != m_state[11:0]) begin
                    e = 1;
                    m_miss++;
                    if (m_miss == THRESH) begin
                        m_locked = 0;
                        run.delete();
                    end
                end else begin
                    m_miss = 0;
                end
            end else if (run.size() == 0) begin
                run.push_back(d);
            end else if (d[11:1] == run[$][10:0]) begin
                run.push_back(d);
                if (run.size() == 9) begin
                    s = {8'h00, run[0]};
                    for (int k = 1; k < 9; k++) s = {s[18:0], run[k][0]};
                    if (s != 20'h0) begin
                        m_locked = 1;
                        m_state  = s;
                        m_miss   = 0;
                    end
                    run.delete();
                end
            end else begin
                run.delete();
                run.push_back(d);
            end
        end
        m_err = e;
        if (clr) m_cnt = '0;
        else if (e && m_cnt != 16'hFFFF) m_cnt++;
    endtask

    function automatic logic [1:0] m_dbg();
        return m_locked ? 2'd2 : (run.size() != 0 ? 2'd1 : 2'd0);
    endfunction

    // One clock of stimulus on the main DUT, checked against the model.
    task automatic cyc(input bit v, input logic [11:0] d, input bit clr);
        @(negedge clk);
        valid = v; data = d; clear_cnt = clr;
        @(posedge clk);
        model_edge(v, d, clr);
        #1;
        chk("locked",    32'(locked),    32'(m_locked));
        chk("error",     32'(error),     32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        chk("state_dbg", 32'(state_dbg), 32'(m_dbg()));
    endtask

    typedef struct {
        bit          v;
        logic [11:0] d;
        bit          e_locked;
        bit          e_error;
        logic [1:0]  e_state;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        tbl[12];
    logic [19:0] g;
    logic [19:0] g2;
    int          nerr2, miss2, words;

    task automatic sat_send(input bit bad_w, input bit clr);
        @(negedge clk);
        g2 = lfsr_step(g2);
        valid2 = 1'b1;
        clear2 = clr;
        if (bad_w) begin
            data2 = g2[11:0] ^ 12'h001;
            miss2++;
            nerr2++;
        end else begin
            data2 = g2[11:0];
            miss2 = 0;
        end
    endtask

    task automatic sat_errors(input int target);
        while (nerr2 < target) sat_send(miss2 != 14, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; valid = 0; data = '0; clear_cnt = 0;
        valid2 = 0; data2 = '0; clear2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_error",  32'(error), 0);
        chk("rst_cnt",    32'(err_count), 0);
        chk("rst_dbg",    32'(state_dbg), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Lock from seed 0x12345, one corrupted word, idle, then a clean word.
        g = 20'h12345;
        for (int i = 0; i < 12; i++) begin
            if (i > 0 && i != 10) g = lfsr_step(g);
            tbl[i].v        = (i != 10);
            tbl[i].d        = (i == 9) ? (g[11:0] ^ 12'h001) : g[11:0];
            tbl[i].e_locked = (i >= 8);
            tbl[i].e_error  = (i == 9);
            tbl[i].e_state  = (i >= 8) ? 2'd2 : 2'd1;
            tbl[i].e_cnt    = (i >= 9) ? 16'd1 : 16'd0;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            valid = tbl[i].v; data = tbl[i].d; clear_cnt = 0;
            @(posedge clk);
            model_edge(tbl[i].v, tbl[i].d, 1'b0);
            #1;
            chk("tbl_locked", 32'(locked),    32'(tbl[i].e_locked));
            chk("tbl_error",  32'(error),     32'(tbl[i].e_error));
            chk("tbl_state",  32'(state_dbg), 32'(tbl[i].e_state));
            chk("tbl_cnt",    32'(err_count), 32'(tbl[i].e_cnt));
        end

        // Loss of lock after four consecutive wrong words.
        for (int i = 0; i < 4; i++) begin
            g = lfsr_step(g);
            cyc(1'b1, g[11:0] ^ 12'h0F0, 1'b0);
            chk("loss_error", 32'(error), 1);
            chk("loss_cnt",   32'(err_count), 32'(i + 2));
            chk("loss_locked", 32'(locked), (i < 3) ? 1 : 0);
        end
        chk("loss_dbg", 32'(state_dbg), 0);

        // Gapped reacquisition: lock must rise on the 9th valid word.
        words = 0;
        while (words < 9) begin
            repeat ($urandom_range(0, 5)) cyc(1'b0, 12'($urandom), 1'b0);
            g = lfsr_step(g);
            cyc(1'b1, g[11:0], 1'b0);
            words++;
            if (words == 8) chk("gap_locked8", 32'(locked), 0);
        end
        chk("gap_locked9", 32'(locked), 1);
        chk("gap_cnt", 32'(err_count), 5);

        // Asynchronous reset while tracking.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 0);
        chk("arst_error",  32'(error), 0);
        chk("arst_cnt",    32'(err_count), 0);
        chk("arst_dbg",    32'(state_dbg), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // All-zero stream must fall back to SEED instead of locking.
        for (int i = 0; i < 9; i++) cyc(1'b1, 12'h000, 1'b0);
        chk("zero_dbg", 32'(state_dbg), 0);
        chk("zero_locked", 32'(locked), 0);

        // Nine fresh words reacquire after reset.
        for (int i = 0; i < 9; i++) begin
            g = lfsr_step(g);
            cyc(1'b1, g[11:0], 1'b0);
        end
        chk("reacq_locked", 32'(locked), 1);

        // Randomized stream: gaps, occasional corruption and clears.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cyc(1'b0, 12'($urandom), $urandom_range(0, 19) == 0);
            end else begin
                g = lfsr_step(g);
                if ($urandom_range(0, 9) == 0)
                    cyc(1'b1, g[11:0] ^ 12'($urandom_range(1, 4095)), $urandom_range(0, 19) == 0);
                else
                    cyc(1'b1, g[11:0], $urandom_range(0, 19) == 0);
            end
        end
        @(negedge clk);
        valid = 0; clear_cnt = 0;

        // Saturation on a wide-threshold instance: never more than 14 misses in a row.
        g2 = 20'hABCDE;
        @(negedge clk);
        valid2 = 1'b1; data2 = g2[11:0];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g2 = lfsr_step(g2);
            data2 = g2[11:0];
        end
        @(posedge clk);
        #1;
        chk("sat_locked", 32'(locked2), 1);
        nerr2 = 0; miss2 = 0;
        sat_errors(1000);
        chk("sat_cnt1000", 32'(cnt2), 1000);
        sat_errors(65535);
        chk("sat_cntmax", 32'(cnt2), 32'hFFFF);
        chk("sat_locked2", 32'(locked2), 1);
        if (miss2 == 14) sat_send(1'b0, 1'b0);
        sat_send(1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("sat_hold", 32'(cnt2), 32'hFFFF);
        chk("sat_err", 32'(error2), 1);
        if (miss2 == 14) sat_send(1'b0, 1'b0);
        sat_send(1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("sat_clear", 32'(cnt2), 0);
        chk("sat_clr_err", 32'(error2), 1);
        chk("sat_clr_locked", 32'(locked2), 1);
        @(negedge clk);
        valid2 = 0; clear2 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
